// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a 16-entry show-ahead byte FIFO.
// Overrun and framing errors are sticky until clr_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rxd,
    input  logic       RE_fifo,
    input  logic       clr_err,
    output logic       Empty,
    output logic       Full,
    output logic [7:0] fifo_data_out,
    output logic       overrun,
    output logic       frame_err
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]         FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]         HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]         BAUD_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]            sync_q;
    logic                  rxd_s;
    state_t                state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  push_req, frame_set;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                  pop, push_ok, overrun_set;

    assign rxd_s = sync_q[1];

    // Receiver FSM: state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receiver FSM: next state; baud counter counts down to zero, sampling on zero
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    baud_d  = HALF_LOAD;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    if (!rxd_s) begin
                        state_d = DATA;
                        baud_d  = FULL_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    baud_d  = FULL_LOAD;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_q == '0) state_d = IDLE;
                else              baud_d  = baud_q - BAUD_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver FSM: outputs
    always_comb begin
        push_req  = 1'b0;
        frame_set = 1'b0;
        if (state_q == STOP && baud_q == '0) begin
            push_req  = rxd_s;
            frame_set = !rxd_s;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign pop         = RE_fifo && !Empty;
    assign push_ok     = push_req && (!Full || pop);
    assign overrun_set = push_req && Full && !pop;

    always_comb begin
        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d     = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_ONE;
        else if (!push_ok && pop) count_d = count_q - CNT_ONE;
        overrun_d   = overrun_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
        frame_err_d = frame_set   ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= shift_q;
    end

    assign Empty         = (count_q == '0);
    assign Full          = (count_q == CNT_FULL);
    assign fifo_data_out = Empty ? 8'h00 : mem[rd_ptr_q];
    assign overrun       = overrun_q;
    assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are bit-banged with CLKS_PER_BIT=16,
// expected bytes are queued at send time and checked by a monitor on every pop.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       rxd = 1'b1;
    logic       RE_fifo = 1'b0;
    logic       clr_err = 1'b0;
    logic       Empty, Full, overrun, frame_err;
    logic [7:0] fifo_data_out;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .rxd(rxd), .RE_fifo(RE_fifo), .clr_err(clr_err),
        .Empty(Empty), .Full(Full), .fifo_data_out(fifo_data_out),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens on the next rising edge whenever RE_fifo && !Empty
    always @(negedge CLK) begin
        if (RST_N && RE_fifo && !Empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %h expected no byte", fifo_data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("pop %h (expected %h)", fifo_data_out, e);
                check("pop_data", fifo_data_out, e);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    // Start bit drives just after edge k; the stop sample lands on edge k+155
    // (2 sync flops + detect edge + CPB/2 + 9*CPB), so the byte shows at k+155.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit exp_push,
                              input bit pop_at_push, input bit clr_at_push,
                              input bit chk_lat, input int abort_at);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        if (exp_push) exp_q.push_back(b);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(posedge CLK); #1;
            if (c == abort_at) break;
            rxd = fr[c / CPB];
            if (c == 154) begin
                RE_fifo = pop_at_push;
                clr_err = clr_at_push;
                if (chk_lat) check("latency_before", {7'd0, Empty}, 8'd1);
            end
            if (c == 155) begin
                RE_fifo = 1'b0;
                clr_err = 1'b0;
                if (chk_lat) check("latency_after", {7'd0, Empty}, 8'd0);
            end
        end
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge CLK); #1;
        RE_fifo = 1'b1;
        @(posedge CLK); #1;
        RE_fifo = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge CLK); #1;
        clr_err = 1'b1;
        @(posedge CLK); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_empty", {7'd0, Empty}, 8'd1);
        check("rst_full", {7'd0, Full}, 8'd0);
        check("rst_overrun", {7'd0, overrun}, 8'd0);
        check("rst_frame_err", {7'd0, frame_err}, 8'd0);
        check("rst_data", fifo_data_out, 8'h00);
        idle(3);
        RST_N = 1'b1;
        idle(5);

        // Single byte, exact latency, then pop
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        check("a5_head", fifo_data_out, 8'hA5);
        pop_one();
        check("a5_empty_after_pop", {7'd0, Empty}, 8'd1);

        // RE_fifo while empty does nothing
        pop_one();
        check("empty_pop_noop", {7'd0, Empty}, 8'd1);

        // Fill to 16, then overrun with 0xFF
        for (int i = 0; i < 16; i++)
            send_frame(8'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("fill_full", {7'd0, Full}, 8'd1);
        check("fill_no_overrun", {7'd0, overrun}, 8'd0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("ovr_flag", {7'd0, overrun}, 8'd1);
        check("ovr_still_full", {7'd0, Full}, 8'd1);
        check("ovr_head_unchanged", fifo_data_out, 8'h00);
        for (int i = 0; i < 16; i++) pop_one();
        check("drain_empty", {7'd0, Empty}, 8'd1);
        check("ovr_sticky", {7'd0, overrun}, 8'd1);
        pulse_clr();
        check("ovr_cleared", {7'd0, overrun}, 8'd0);

        // Full FIFO, pop coincides with push of 0x77
        for (int i = 0; i < 16; i++)
            send_frame(8'h20 + 8'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        check("simul_no_overrun", {7'd0, overrun}, 8'd0);
        check("simul_full", {7'd0, Full}, 8'd1);
        check("simul_head", fifo_data_out, 8'h21);
        for (int i = 0; i < 16; i++) pop_one();
        check("simul_drained", {7'd0, Empty}, 8'd1);

        // Framing error, then clear
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(3 * CPB);
        check("fe_flag", {7'd0, frame_err}, 8'd1);
        check("fe_empty", {7'd0, Empty}, 8'd1);
        pulse_clr();
        check("fe_cleared", {7'd0, frame_err}, 8'd0);

        // Set wins over a coincident clear
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(3 * CPB);
        check("fe_set_dominant", {7'd0, frame_err}, 8'd1);
        pulse_clr();

        // Glitch: 4 cycles low is a false start
        @(posedge CLK); #1;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(3 * CPB);
        check("glitch_empty", {7'd0, Empty}, 8'd1);
        check("glitch_no_fe", {7'd0, frame_err}, 8'd0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        pop_one();

        // Reset in the middle of data bit 4 with a byte already queued
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("pre_rst_head", fifo_data_out, 8'h11);
        send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5 * CPB + 5);
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_empty", {7'd0, Empty}, 8'd1);
        check("midrst_data", fifo_data_out, 8'h00);
        idle(4);
        check("midrst_hold_empty", {7'd0, Empty}, 8'd1);
        check("midrst_hold_full", {7'd0, Full}, 8'd0);
        RST_N = 1'b1;
        idle(3 * CPB);
        check("postrst_empty", {7'd0, Empty}, 8'd1);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        pop_one();
        idle(2);
        check("final_empty", {7'd0, Empty}, 8'd1);
        check("scoreboard_left", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
